// File: rtl/dot_product_accumulator.sv
// Dot-product accumulator: sums a stream of unsigned products per vector
// and emits sum, term count, overflow and truncation flags.
module dot_product_accumulator #(
  parameter int PROD_W    = 64,
  parameter int ACC_W     = 72,
  parameter int MAX_TERMS = 256,
  localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow,
  output logic              out_trunc,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   ocnt_q, ocnt_d;
  logic               oovf_q, oovf_d;
  logic               trunc_q, trunc_d;
  logic               valid_q, valid_d;

  logic               accept;
  logic               hit_max;
  logic               vend;
  logic               carry;
  logic [ACC_W-1:0]   base;
  logic [ACC_W:0]     sum_ext;
  logic [CNT_W-1:0]   cnt_inc;

  // Ready is a decode of the registered state, held low while in reset.
  assign in_ready = (state_q == ACCUM) && !rst;

  // Datapath: next partial sum, carry-out and end-of-vector detection.
  always_comb begin
    accept  = in_valid && (state_q == ACCUM);
    base    = (cnt_q == '0) ? '0 : acc_q;
    sum_ext = {1'b0, base}
            + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    carry   = sum_ext[ACC_W];
    cnt_inc = cnt_q + CNT_W'(1);
    hit_max = (cnt_inc == CNT_W'(MAX_TERMS));
    vend    = accept && (in_last || hit_max);
  end

  // Next-state and result-register logic for the ACCUM/DONE handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    trunc_d = trunc_q;
    valid_d = valid_q;
    if (accept) begin
      acc_d = sum_ext[ACC_W-1:0];
      cnt_d = cnt_inc;
      ovf_d = ovf_q | carry;
    end
    if (vend) begin
      sum_d   = sum_ext[ACC_W-1:0];
      ocnt_d  = cnt_inc;
      oovf_d  = ovf_q | carry;
      trunc_d = hit_max && !in_last;
      valid_d = 1'b1;
      state_d = DONE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
    if (state_q == DONE && valid_q && out_ready) begin
      valid_d = 1'b0;
      state_d = ACCUM;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
      trunc_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
      trunc_q <= trunc_d;
      valid_q <= valid_d;
    end
  end

  assign out_sum      = sum_q;
  assign out_count    = ocnt_q;
  assign out_overflow = oovf_q;
  assign out_trunc    = trunc_q;
  assign out_valid    = valid_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Scoreboard bench: u0 uses default widths, u1 uses a 64-bit
// accumulator and a 4-term limit.
module tb_dot_product_accumulator;

  typedef struct packed {
    logic [71:0] sum;
    logic [8:0]  cnt;
    logic        ovf;
    logic        trunc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ip[2];
  logic        iv[2];
  logic        il[2];
  logic        ir[2];
  logic [71:0] osum[2];
  logic [8:0]  ocnt[2];
  logic        oovf[2];
  logic        otr[2];
  logic        ov[2];
  logic        ordy[2];

  logic [63:0] s1;
  logic [2:0]  c1;

  res_t q0[$];
  res_t q1[$];

  int accw[2] = '{72, 64};
  int maxt[2] = '{256, 4};
  logic [71:0] macc[2];
  int          mcnt[2];
  logic        movf[2];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dot_product_accumulator u0 (
    .clk(clk), .rst(rst),
    .in_product(ip[0]), .in_valid(iv[0]), .in_last(il[0]),
    .in_ready(ir[0]),
    .out_sum(osum[0]), .out_count(ocnt[0]),
    .out_overflow(oovf[0]), .out_trunc(otr[0]),
    .out_valid(ov[0]), .out_ready(ordy[0])
  );

  dot_product_accumulator #(.ACC_W(64), .MAX_TERMS(4)) u1 (
    .clk(clk), .rst(rst),
    .in_product(ip[1]), .in_valid(iv[1]), .in_last(il[1]),
    .in_ready(ir[1]),
    .out_sum(s1), .out_count(c1),
    .out_overflow(oovf[1]), .out_trunc(otr[1]),
    .out_valid(ov[1]), .out_ready(ordy[1])
  );

  assign osum[1] = {8'h00, s1};
  assign ocnt[1] = {6'd0, c1};

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic model_clear(input int d);
    macc[d] = '0;
    mcnt[d] = 0;
    movf[d] = 1'b0;
  endtask

  task automatic model_accept(input int d, input logic [63:0] p,
                              input logic last, output bit ended);
    logic [72:0] s;
    logic [71:0] r;
    logic        c;
    res_t        e;
    s = {1'b0, macc[d]} + {9'd0, p};
    if (accw[d] == 64) begin
      c = s[64];
      r = {8'h00, s[63:0]};
    end else begin
      c = s[72];
      r = s[71:0];
    end
    macc[d] = r;
    mcnt[d] = mcnt[d] + 1;
    movf[d] = movf[d] | c;
    ended = last || (mcnt[d] == maxt[d]);
    if (ended) begin
      e.sum   = r;
      e.cnt   = 9'(mcnt[d]);
      e.ovf   = movf[d];
      e.trunc = !last && (mcnt[d] == maxt[d]);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      model_clear(d);
    end
  endtask

  // Drive one term, wait for acceptance, then check result latency.
  task automatic send(input int d, input logic [63:0] p,
                      input logic last);
    bit done;
    bit ended;
    done = 0;
    ip[d] = p;
    iv[d] = 1'b1;
    il[d] = last;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (ir[d]) done = 1;
      @(posedge clk);
      #1;
    end
    iv[d] = 1'b0;
    il[d] = 1'b0;
    if (!done) begin
      chk("send_timeout", 72'd0, 72'd1);
      return;
    end
    model_accept(d, p, last, ended);
    if (ended) begin
      @(negedge clk);
      chk("latency_valid", {71'd0, ov[d]}, 72'd1);
      @(posedge clk);
      #1;
    end
  endtask

  // Result monitor: compare each handshaken result with the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && ov[d] === 1'b1 && ordy[d] === 1'b1) begin
        res_t e;
        bit   have;
        have = 0;
        if (d == 0 && q0.size() > 0) begin
          e = q0.pop_front();
          have = 1;
        end else if (d == 1 && q1.size() > 0) begin
          e = q1.pop_front();
          have = 1;
        end
        if (!have) begin
          chk("unexpected_result", 72'd1, 72'd0);
        end else begin
          chk("out_sum", osum[d], e.sum);
          chk("out_count", {63'd0, ocnt[d]}, {63'd0, e.cnt});
          chk("out_overflow", {71'd0, oovf[d]}, {71'd0, e.ovf});
          chk("out_trunc", {71'd0, otr[d]}, {71'd0, e.trunc});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ip[d] = '0;
      iv[d] = 1'b0;
      il[d] = 1'b0;
      ordy[d] = 1'b1;
      model_clear(d);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {71'd0, ir[0]}, 72'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_after", {71'd0, ir[0]}, 72'd1);
    chk("rst_out_valid", {71'd0, ov[0]}, 72'd0);
    chk("rst_out_sum", osum[0], 72'd0);
    chk("rst_out_count", {63'd0, ocnt[0]}, 72'd0);
    chk("rst_flags", {70'd0, oovf[0], otr[0]}, 72'd0);
    chk("rst_u1_ready", {71'd0, ir[1]}, 72'd1);
    @(posedge clk);
    #1;

    // basic three-term vector
    send(0, 64'd10, 1'b0);
    send(0, 64'd20, 1'b0);
    send(0, 64'd30, 1'b1);

    // single maximal product, no wrap in 72 bits
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    // overflow in the 64-bit accumulator, then a clean vector
    send(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(1, 64'd2, 1'b1);
    send(1, 64'd5, 1'b1);

    // backpressure with a pending term
    ordy[0] = 1'b0;
    send(0, 64'd4, 1'b0);
    send(0, 64'd4, 1'b1);
    ip[0] = 64'd9;
    iv[0] = 1'b1;
    il[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_sum_stable", osum[0], 72'd8);
      chk("bp_valid", {71'd0, ov[0]}, 72'd1);
      chk("bp_in_ready", {71'd0, ir[0]}, 72'd0);
    end
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    chk("bp_valid_drop", {71'd0, ov[0]}, 72'd0);
    chk("bp_ready_back", {71'd0, ir[0]}, 72'd1);
    ordy[0] = 1'b1;
    send(0, 64'd9, 1'b1);

    // truncation at the 4-term limit, then a new vector
    for (int i = 0; i < 5; i++) send(1, 64'd1, 1'b0);
    send(1, 64'd1, 1'b0);
    send(1, 64'd1, 1'b0);
    send(1, 64'd1, 1'b1);
    // last arriving exactly on the limit term
    for (int i = 0; i < 3; i++) send(1, 64'd1, 1'b0);
    send(1, 64'd1, 1'b1);

    // reset in the middle of a vector
    send(0, 64'd7, 1'b0);
    send(0, 64'd7, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {71'd0, ir[0]}, 72'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear(0);
    model_clear(1);
    send(0, 64'd5, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("q0_drained", 72'(q0.size()), 72'd0);
    chk("q1_drained", 72'(q1.size()), 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
